// File: rtl/iterative_divider_if.sv
// Request/result bus for the iterative divider.
// Handshake: a transfer happens on a rising clock edge where valid && ready
// are both high. The sender keeps valid and its payload steady until that
// edge; ready may change freely and never depends on valid in the same
// cycle. The request side uses inValid/inReady, the result side uses
// outValid/outReady.
interface iterative_divider_if #(
   parameter int WIDTH = 32
);
   logic             inValid;
   logic             inReady;
   logic             isSigned;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             cancel;
   logic             outValid;
   logic             outReady;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             divideByZero;
   logic             overflow;

   // Requester / result consumer side.
   modport master (
      output inValid, isSigned, dividend, divisor, cancel, outReady,
      input  inReady, outValid, quotient, remainder, divideByZero, overflow
   );

   // Divider side.
   modport slave (
      input  inValid, isSigned, dividend, divisor, cancel, outReady,
      output inReady, outValid, quotient, remainder, divideByZero, overflow
   );
endinterface

// File: rtl/iterative_divider.sv
// Iterative restoring divider, STEP quotient bits per cycle, MSB first.
// Signed operation divides magnitudes and applies truncating signs at the end.
// Trivial cases (x/0, most-negative/-1, 0/x) bypass the iteration and pass
// through FIXUP so every result is published from the same register stage.
module iterative_divider #(
   parameter int WIDTH = 32,
   parameter int STEP  = 1
) (
   input  logic               clock,
   input  logic               resetN,
   iterative_divider_if.slave bus,
   output logic [1:0]         debugState
);

   typedef enum logic [1:0] {IDLE, RUN, FIXUP, DONE} state_t;
   typedef enum logic [1:0] {K_NORMAL, K_DBZ, K_OVF, K_ZERO} kind_t;

   localparam int ITER = WIDTH / STEP;
   localparam int CW   = $clog2(ITER) + 1;
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   state_t           state_q, state_d;
   kind_t            kind_q, kind_in;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH:0]   rem_q, dvs_q, rem_step, dvs_mag;
   logic [WIDTH-1:0] quo_q, quo_step, dvd_q, dvd_mag;
   logic             sign_a_q, sign_b_q, dvd_neg, dvs_neg;
   logic [WIDTH-1:0] quotient_q, remainder_q, q_fix, r_fix;
   logic             dbz_q, ovf_q;

   assign debugState       = state_q;
   assign bus.inReady      = (state_q == IDLE);
   assign bus.outValid     = (state_q == DONE);
   assign bus.quotient     = quotient_q;
   assign bus.remainder    = remainder_q;
   assign bus.divideByZero = dbz_q;
   assign bus.overflow     = ovf_q;

   // Classify the incoming request and form operand magnitudes. The dividend
   // magnitude of the most-negative value is exact as a WIDTH-bit unsigned.
   always_comb begin
      kind_in = K_NORMAL;
      if (bus.divisor == '0)
         kind_in = K_DBZ;
      else if (bus.isSigned && bus.dividend == MOST_NEG && bus.divisor == '1)
         kind_in = K_OVF;
      else if (bus.dividend == '0)
         kind_in = K_ZERO;
      dvd_neg = bus.isSigned & bus.dividend[WIDTH-1];
      dvs_neg = bus.isSigned & bus.divisor[WIDTH-1];
      dvd_mag = dvd_neg ? (~bus.dividend + 1'b1) : bus.dividend;
      dvs_mag = {1'b0, (dvs_neg ? (~bus.divisor + 1'b1) : bus.divisor)};
   end

   // STEP restoring shift/compare/subtract steps; quotient bits shift in at
   // the bottom of quo_q as dividend bits leave at the top.
   always_comb begin
      rem_step = rem_q;
      quo_step = quo_q;
      for (int i = 0; i < STEP; i++) begin
         rem_step = {rem_step[WIDTH-1:0], quo_step[WIDTH-1]};
         quo_step = {quo_step[WIDTH-2:0], 1'b0};
         if (rem_step >= dvs_q) begin
            rem_step    = rem_step - dvs_q;
            quo_step[0] = 1'b1;
         end
      end
   end

   // Final result selection: trivial cases or sign-corrected magnitudes.
   always_comb begin
      q_fix = quo_q;
      r_fix = rem_q[WIDTH-1:0];
      case (kind_q)
         K_DBZ:  begin q_fix = '1;    r_fix = dvd_q; end
         K_OVF:  begin q_fix = dvd_q; r_fix = '0;    end
         K_ZERO: begin q_fix = '0;    r_fix = '0;    end
         default: begin
            if (sign_a_q ^ sign_b_q) q_fix = -quo_q;
            if (sign_a_q)            r_fix = -rem_q[WIDTH-1:0];
         end
      endcase
   end

   // State register.
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic; cancel only matters while work is in flight.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (bus.inValid) state_d = (kind_in == K_NORMAL) ? RUN : FIXUP;
         RUN: begin
            if (bus.cancel)                       state_d = IDLE;
            else if (cnt_q == CW'(ITER - 1))      state_d = FIXUP;
         end
         FIXUP: state_d = bus.cancel ? IDLE : DONE;
         DONE:  if (bus.outReady) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath: load on accept, iterate in RUN, publish results in FIXUP.
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         cnt_q       <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         dvs_q       <= '0;
         dvd_q       <= '0;
         sign_a_q    <= 1'b0;
         sign_b_q    <= 1'b0;
         kind_q      <= K_NORMAL;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (bus.inValid) begin
               cnt_q    <= '0;
               rem_q    <= '0;
               quo_q    <= dvd_mag;
               dvs_q    <= dvs_mag;
               dvd_q    <= bus.dividend;
               sign_a_q <= dvd_neg;
               sign_b_q <= dvs_neg;
               kind_q   <= kind_in;
               dbz_q    <= 1'b0;
               ovf_q    <= 1'b0;
            end
            RUN: if (!bus.cancel) begin
               rem_q <= rem_step;
               quo_q <= quo_step;
               cnt_q <= cnt_q + 1'b1;
            end
            FIXUP: if (!bus.cancel) begin
               quotient_q  <= q_fix;
               remainder_q <= r_fix;
               dbz_q       <= (kind_q == K_DBZ);
               ovf_q       <= (kind_q == K_OVF);
            end
            default: ;
         endcase
      end
   end

endmodule
